// File: rtl/mod14_compose_if.sv
// ============================================================================
// Module      : mod14_compose_if
// Description : Valid/ready handshake bundle for the mod-14 value rebuilder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mod14_compose_if #(
  parameter int WIDTH = 8,
  parameter int RES_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] residue;
  logic [WIDTH-1:0] quotient;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] outputy;
  logic             err_residue;
  logic             overflow;

  // master: the producer/consumer environment around the block
  modport master (
    output in_valid, residue, quotient, out_ready,
    input  in_ready, out_valid, outputy, err_residue, overflow
  );

  // slave: the rebuilder itself
  modport slave (
    input  in_valid, residue, quotient, out_ready,
    output in_ready, out_valid, outputy, err_residue, overflow
  );
endinterface

`default_nettype wire

// File: rtl/mod14_compose.sv
// ============================================================================
// Module      : mod14_compose
// Description : Rebuilds value = quotient*MODULUS + residue by repeated
//               addition, one add per cycle. Optional build macro:
//               MOD14_COMPOSE_SATURATE_EN (clamp to all-ones on overflow).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod14_compose #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 14,
  parameter int RES_W   = 4
) (
  input  wire logic        clock,
  input  wire logic        reset,
  mod14_compose_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH:0]   c_mod_ext = (WIDTH+1)'(MODULUS);
  localparam logic [RES_W:0]   c_mod_res = (RES_W+1)'(MODULUS);
  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] outputy_q, outputy_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   sum_w;
  logic             res_bad_w;

  assign sum_w     = {1'b0, acc_q} + c_mod_ext;
  assign res_bad_w = ({1'b0, bus.residue} >= c_mod_res);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    outputy_d = outputy_q;
    err_d     = err_q;
    ovf_d     = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // An illegal residue runs through ACCUM with a zero count and zero
          // accumulator, so it finishes with the same latency as quotient=0.
          acc_d   = res_bad_w ? '0 : WIDTH'(bus.residue);
          cnt_d   = res_bad_w ? '0 : bus.quotient;
          err_d   = res_bad_w;
          ovf_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - c_one;
`ifdef MOD14_COMPOSE_SATURATE_EN
          if (ovf_q || sum_w[WIDTH]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_w[WIDTH-1:0];
          end
`else
          acc_d = sum_w[WIDTH-1:0];
          if (sum_w[WIDTH]) begin
            ovf_d = 1'b1;
          end
`endif
        end else begin
          outputy_d = acc_q;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      outputy_q   <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      outputy_q   <= outputy_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.outputy     = outputy_q;
  assign bus.err_residue = err_q;
  assign bus.overflow    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mod14_compose.sv
// ============================================================================
// Module      : tb_mod14_compose
// Description : Directed self-checking bench for mod14_compose.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod14_compose;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mod14_compose_if #(.WIDTH(8), .RES_W(4)) ifc ();

  mod14_compose #(.WIDTH(8), .MODULUS(14), .RES_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clock = ~clock;

  // Present one transaction, let it be accepted, then wait for out_valid.
  // lat = edges after the accepting edge until out_valid is seen.
  task automatic do_txn(input logic [7:0] q, input logic [3:0] r, output int lat);
    ifc.in_valid = 1'b1;
    ifc.quotient = q;
    ifc.residue  = r;
    @(posedge clock); #1;
    ifc.in_valid = 1'b0;
    ifc.quotient = 8'($urandom);
    ifc.residue  = 4'($urandom);
    lat = 0;
    while (!ifc.out_valid && lat < 300) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic drain();
    ifc.out_ready = 1'b1;
    @(posedge clock); #1;
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 || ifc.outputy !== 8'd0 ||
        ifc.err_residue !== 1'b0 || ifc.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b y=%0d err=%b ovf=%b, want 1 0 0 0 0",
               ifc.in_ready, ifc.out_valid, ifc.outputy, ifc.err_residue, ifc.overflow);
    end
  endtask

  task automatic test_basic();
    int lat;
    do_txn(8'd5, 4'd3, lat);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL basic_latency: got %0d want 6", lat); end
    checks++;
    if (ifc.outputy !== 8'd73 || ifc.err_residue !== 1'b0 || ifc.overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_value: y=%0d err=%b ovf=%b want 73 0 0",
               ifc.outputy, ifc.err_residue, ifc.overflow);
    end
    drain();
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_drain: vld=%b rdy=%b want 0 1", ifc.out_valid, ifc.in_ready);
    end
  endtask

  task automatic test_q0();
    int lat;
    do_txn(8'd0, 4'd13, lat);
    checks++;
    if (lat !== 1 || ifc.outputy !== 8'd13 || ifc.err_residue !== 1'b0) begin
      errors++;
      $display("FAIL q0: lat=%0d y=%0d err=%b want 1 13 0", lat, ifc.outputy, ifc.err_residue);
    end
    drain();
  endtask

  task automatic test_max_no_ovf();
    int lat;
    do_txn(8'd18, 4'd3, lat);
    checks++;
    if (lat !== 19 || ifc.outputy !== 8'd255 || ifc.overflow !== 1'b0) begin
      errors++;
      $display("FAIL max_no_ovf: lat=%0d y=%0d ovf=%b want 19 255 0", lat, ifc.outputy, ifc.overflow);
    end
    drain();
  endtask

  task automatic test_err_residue();
    int lat;
    do_txn(8'd7, 4'd14, lat);
    checks++;
    if (lat !== 1 || ifc.outputy !== 8'd0 || ifc.err_residue !== 1'b1 ||
        ifc.overflow !== 1'b0 || ifc.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_residue: lat=%0d y=%0d err=%b ovf=%b rdy=%b want 1 0 1 0 0",
               lat, ifc.outputy, ifc.err_residue, ifc.overflow, ifc.in_ready);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL err_hold: rdy=%b vld=%b want 0 1", ifc.in_ready, ifc.out_valid);
    end
    drain();
    // A legal transaction afterwards must clear the error flag.
    do_txn(8'd1, 4'd2, lat);
    checks++;
    if (ifc.outputy !== 8'd16 || ifc.err_residue !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: y=%0d err=%b want 16 0", ifc.outputy, ifc.err_residue);
    end
    drain();
  endtask

  task automatic test_overflow();
    int lat;
    logic [7:0] exp_y;
`ifdef MOD14_COMPOSE_SATURATE_EN
    exp_y = 8'd255;
`else
    exp_y = 8'd1;
`endif
    do_txn(8'd18, 4'd5, lat);
    checks++;
    if (lat !== 19 || ifc.outputy !== exp_y || ifc.overflow !== 1'b1 || ifc.err_residue !== 1'b0) begin
      errors++;
      $display("FAIL overflow: lat=%0d y=%0d ovf=%b err=%b want 19 %0d 1 0",
               lat, ifc.outputy, ifc.overflow, ifc.err_residue, exp_y);
    end
    drain();
    // The next transaction must start with overflow cleared.
    do_txn(8'd2, 4'd0, lat);
    checks++;
    if (ifc.outputy !== 8'd28 || ifc.overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: y=%0d ovf=%b want 28 0", ifc.outputy, ifc.overflow);
    end
    drain();
  endtask

  task automatic test_stall();
    int lat;
    do_txn(8'd2, 4'd1, lat);
    ifc.in_valid = 1'b1;
    ifc.quotient = 8'd9;
    ifc.residue  = 4'd9;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.outputy !== 8'd29 || ifc.err_residue !== 1'b0 ||
          ifc.overflow !== 1'b0 || ifc.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: vld=%b y=%0d err=%b ovf=%b rdy=%b want 1 29 0 0 0",
                 i, ifc.out_valid, ifc.outputy, ifc.err_residue, ifc.overflow, ifc.in_ready);
      end
      @(posedge clock); #1;
    end
    ifc.in_valid = 1'b0;
    drain();
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: vld=%b rdy=%b want 0 1", ifc.out_valid, ifc.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit saw_valid;
    ifc.in_valid = 1'b1;
    ifc.quotient = 8'd10;
    ifc.residue  = 4'd2;
    @(posedge clock); #1;
    ifc.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 || ifc.outputy !== 8'd0 ||
        ifc.err_residue !== 1'b0 || ifc.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: rdy=%b vld=%b y=%0d err=%b ovf=%b want 1 0 0 0 0",
               ifc.in_ready, ifc.out_valid, ifc.outputy, ifc.err_residue, ifc.overflow);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      if (ifc.out_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_result: out_valid seen=%b want 0", saw_valid);
    end
    do_txn(8'd1, 4'd0, lat);
    checks++;
    if (lat !== 2 || ifc.outputy !== 8'd14) begin
      errors++;
      $display("FAIL reset_mid_next: lat=%0d y=%0d want 2 14", lat, ifc.outputy);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int lat;
    do_txn(8'd3, 4'd0, lat);
    checks++;
    if (lat !== 4 || ifc.outputy !== 8'd42) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d y=%0d want 4 42", lat, ifc.outputy);
    end
    drain();
    do_txn(8'd4, 4'd13, lat);
    checks++;
    if (lat !== 5 || ifc.outputy !== 8'd69) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d y=%0d want 5 69", lat, ifc.outputy);
    end
    drain();
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.residue   = '0;
    ifc.quotient  = '0;
    ifc.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    test_reset();
    test_basic();
    test_q0();
    test_max_no_ovf();
    test_err_residue();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
